// File: rtl/td4p_core.sv
// td4p_core: parametrised single-cycle accumulator core (PC, A, B, OUT, carry).
// Program memory is external with a combinational read: IM_Q must be valid for
// the address on IM_AD in the same cycle.
// Optional build macro TD4P_STEP_EN adds a STEP input. When it is defined,
// state only advances on edges where STEP is high.
module td4p_core #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              CK,
  input  logic              RST,
`ifdef TD4P_STEP_EN
  input  logic              STEP,
`endif
  output logic [ADDR_W-1:0] IM_AD,
  input  logic [DATA_W+3:0] IM_Q,
  input  logic [DATA_W-1:0] IN_PORT,
  output logic [DATA_W-1:0] OUT_PORT,
  output logic              OUT_VLD,
  output logic              CFLAG,
  output logic              HALTED,
  output logic [DATA_W-1:0] A_OUT,
  output logic [DATA_W-1:0] B_OUT
);

  typedef enum logic [1:0] {SEL_A = 2'd0, SEL_B = 2'd1, SEL_IN = 2'd2, SEL_ZERO = 2'd3} sel_e;

  logic [3:0]        op_s;
  logic [DATA_W-1:0] im_s;
  logic              step_s;
  sel_e              sel_s;
  logic              ld_a_s, ld_b_s, ld_out_s, jump_s, hlt_s;
  logic [DATA_W-1:0] y_s;
  logic [DATA_W:0]   sum_s;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic              vld_q, vld_d, c_q, c_d, halt_q, halt_d;

  assign op_s = IM_Q[DATA_W+3:DATA_W];
  assign im_s = IM_Q[DATA_W-1:0];

`ifdef TD4P_STEP_EN
  assign step_s = STEP;
`else
  assign step_s = 1'b1;
`endif

  // Opcode decode: source select, destination enables, jump and halt.
  always_comb begin
    sel_s    = SEL_ZERO;
    ld_a_s   = 1'b0;
    ld_b_s   = 1'b0;
    ld_out_s = 1'b0;
    jump_s   = 1'b0;
    hlt_s    = 1'b0;
    case (op_s)
      4'b0001: begin sel_s = SEL_A;  ld_a_s = 1'b1; end
      4'b0010: begin sel_s = SEL_B;  ld_a_s = 1'b1; end
      4'b0011: begin sel_s = SEL_IN; ld_a_s = 1'b1; end
      4'b0100: begin ld_a_s = 1'b1; end
      4'b0101: begin sel_s = SEL_A;  ld_b_s = 1'b1; end
      4'b0110: begin sel_s = SEL_B;  ld_b_s = 1'b1; end
      4'b0111: begin sel_s = SEL_IN; ld_b_s = 1'b1; end
      4'b1000: begin ld_b_s = 1'b1; end
      4'b1001: begin sel_s = SEL_B;  ld_out_s = 1'b1; end
      4'b1010: begin ld_out_s = 1'b1; end
      4'b1011: begin jump_s = 1'b1; end
      4'b1100: begin jump_s = ~c_q; end
      4'b1101: begin sel_s = SEL_A;  ld_out_s = 1'b1; end
      4'b1110: begin jump_s = c_q; end
      4'b1111: begin hlt_s = 1'b1; end
      default: begin sel_s = SEL_ZERO; end
    endcase
  end

  // Source selector and adder; immediate loads pass through with Y=0.
  always_comb begin
    y_s = {DATA_W{1'b0}};
    case (sel_s)
      SEL_A:   y_s = a_q;
      SEL_B:   y_s = b_q;
      SEL_IN:  y_s = IN_PORT;
      default: y_s = {DATA_W{1'b0}};
    endcase
    sum_s = {1'b0, y_s} + {1'b0, im_s};
  end

  // Next-state: hold by default; execute only when running and stepped.
  always_comb begin
    pc_d   = pc_q;
    a_d    = a_q;
    b_d    = b_q;
    out_d  = out_q;
    c_d    = c_q;
    halt_d = halt_q;
    vld_d  = 1'b0;
    if (!halt_q && step_s) begin
      if (hlt_s) begin
        halt_d = 1'b1;
      end else begin
        c_d = sum_s[DATA_W];
        if (ld_a_s) begin
          a_d = sum_s[DATA_W-1:0];
        end else begin
          a_d = a_q;
        end
        if (ld_b_s) begin
          b_d = sum_s[DATA_W-1:0];
        end else begin
          b_d = b_q;
        end
        if (ld_out_s) begin
          out_d = sum_s[DATA_W-1:0];
          vld_d = 1'b1;
        end else begin
          out_d = out_q;
        end
        if (jump_s) begin
          pc_d = im_s[ADDR_W-1:0];
        end else begin
          pc_d = pc_q + ADDR_W'(1);
        end
      end
    end else begin
      vld_d = 1'b0;
    end
  end

  // State registers with synchronous reset overriding execution and halt.
  always_ff @(posedge CK) begin
    if (RST) begin
      pc_q   <= {ADDR_W{1'b0}};
      a_q    <= {DATA_W{1'b0}};
      b_q    <= {DATA_W{1'b0}};
      out_q  <= {DATA_W{1'b0}};
      c_q    <= 1'b0;
      vld_q  <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      out_q  <= out_d;
      c_q    <= c_d;
      vld_q  <= vld_d;
      halt_q <= halt_d;
    end
  end

  assign IM_AD    = pc_q;
  assign OUT_PORT = out_q;
  assign OUT_VLD  = vld_q;
  assign CFLAG    = c_q;
  assign HALTED   = halt_q;
  assign A_OUT    = a_q;
  assign B_OUT    = b_q;

endmodule

// File: tb/tb_td4p_core.sv
// tb_td4p_core: table-driven and randomized checks of td4p_core at two sizes
// (4/4 and 8/6) against an instruction-level reference model.
module tb_td4p_core;

  logic CK = 1'b0;
  logic rst = 1'b0;
  logic step = 1'b1;
  always #5 CK = ~CK;

  // Core 0: DATA_W=4, ADDR_W=4
  logic [7:0]  mem4 [0:15];
  logic [3:0]  ad4, in4, out4, a4, b4;
  logic [7:0]  q4;
  logic        vld4, c4, h4;
  // Core 1: DATA_W=8, ADDR_W=6
  logic [11:0] mem8 [0:63];
  logic [5:0]  ad8;
  logic [7:0]  in8, out8, a8, b8;
  logic [11:0] q8;
  logic        vld8, c8, h8;

  assign q4 = mem4[ad4];
  assign q8 = mem8[ad8];

  td4p_core #(.DATA_W(4), .ADDR_W(4)) dut4 (
    .CK(CK), .RST(rst),
`ifdef TD4P_STEP_EN
    .STEP(step),
`endif
    .IM_AD(ad4), .IM_Q(q4), .IN_PORT(in4), .OUT_PORT(out4), .OUT_VLD(vld4),
    .CFLAG(c4), .HALTED(h4), .A_OUT(a4), .B_OUT(b4));

  td4p_core #(.DATA_W(8), .ADDR_W(6)) dut8 (
    .CK(CK), .RST(rst),
`ifdef TD4P_STEP_EN
    .STEP(step),
`endif
    .IM_AD(ad8), .IM_Q(q8), .IN_PORT(in8), .OUT_PORT(out8), .OUT_VLD(vld8),
    .CFLAG(c8), .HALTED(h8), .A_OUT(a8), .B_OUT(b8));

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = 4-bit core, 1 = 8-bit core
  int mp[2], ma[2], mb[2], mo[2], mc[2], mv[2], mh[2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One instruction of the ISA, applied to model k at an edge.
  task automatic model_step(input int k, input int dw, input int aw, input int instr,
                            input int inp, input bit r, input bit s);
    int dm, am, op, im, sum, nxt, x;
    dm = (1 << dw) - 1;
    am = (1 << aw) - 1;
    op = (instr >> dw) & 15;
    im = instr & dm;
    x  = inp & dm;
    if (r) begin
      mp[k] = 0; ma[k] = 0; mb[k] = 0; mo[k] = 0; mc[k] = 0; mv[k] = 0; mh[k] = 0;
    end else if (mh[k] != 0 || !s) begin
      mv[k] = 0;
    end else if (op == 15) begin
      mh[k] = 1;
      mv[k] = 0;
    end else begin
      sum = im;
      nxt = (mp[k] + 1) & am;
      mv[k] = 0;
      case (op)
        1:  begin sum = ma[k] + im; ma[k] = sum & dm; end
        2:  begin sum = mb[k] + im; ma[k] = sum & dm; end
        3:  begin sum = x + im;     ma[k] = sum & dm; end
        4:  ma[k] = im;
        5:  begin sum = ma[k] + im; mb[k] = sum & dm; end
        6:  begin sum = mb[k] + im; mb[k] = sum & dm; end
        7:  begin sum = x + im;     mb[k] = sum & dm; end
        8:  mb[k] = im;
        9:  begin sum = mb[k] + im; mo[k] = sum & dm; mv[k] = 1; end
        10: begin mo[k] = im; mv[k] = 1; end
        11: nxt = im & am;
        12: if (mc[k] == 0) nxt = im & am;
        13: begin sum = ma[k] + im; mo[k] = sum & dm; mv[k] = 1; end
        14: if (mc[k] == 1) nxt = im & am;
        default: ;
      endcase
      mc[k] = sum >> dw;
      mp[k] = nxt;
    end
  endtask

  task automatic tick();
    model_step(0, 4, 4, int'(mem4[mp[0]]), int'(in4), rst, step);
    model_step(1, 8, 6, int'(mem8[mp[1]]), int'(in8), rst, step);
    @(posedge CK);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pc4"},  int'(ad4),  mp[0]);
    check({tag, "_a4"},   int'(a4),   ma[0]);
    check({tag, "_b4"},   int'(b4),   mb[0]);
    check({tag, "_out4"}, int'(out4), mo[0]);
    check({tag, "_c4"},   int'(c4),   mc[0]);
    check({tag, "_vld4"}, int'(vld4), mv[0]);
    check({tag, "_h4"},   int'(h4),   mh[0]);
    check({tag, "_pc8"},  int'(ad8),  mp[1]);
    check({tag, "_a8"},   int'(a8),   ma[1]);
    check({tag, "_b8"},   int'(b8),   mb[1]);
    check({tag, "_out8"}, int'(out8), mo[1]);
    check({tag, "_c8"},   int'(c8),   mc[1]);
    check({tag, "_vld8"}, int'(vld8), mv[1]);
    check({tag, "_h8"},   int'(h8),   mh[1]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    int         prog;
    logic [3:0] a, b, o;
    logic       c, v;
    logic [3:0] pc;
  } vec_t;

  vec_t       tv [15];
  logic [7:0] prog_tbl [3][8];

  // Safety net: the bench only uses fixed cycle counts, but never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem4[i] = 8'h00;
    for (int i = 0; i < 64; i++) mem8[i] = 12'h000;
    in4 = 4'h0;
    in8 = 8'h00;

    prog_tbl[0] = '{8'h43, 8'h15, 8'h50, 8'h91, 8'h00, 8'h00, 8'h00, 8'h00};
    prog_tbl[1] = '{8'h4F, 8'h11, 8'hC0, 8'h11, 8'hC0, 8'h00, 8'h00, 8'h00};
    prog_tbl[2] = '{8'h4F, 8'h11, 8'hE4, 8'h11, 8'hE0, 8'h00, 8'h00, 8'h00};
    //          prog  a     b     out   c     v     pc
    tv[0]  = '{0, 4'h3, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1};
    tv[1]  = '{0, 4'h8, 4'h0, 4'h0, 1'b0, 1'b0, 4'h2};
    tv[2]  = '{0, 4'h8, 4'h8, 4'h0, 1'b0, 1'b0, 4'h3};
    tv[3]  = '{0, 4'h8, 4'h8, 4'h9, 1'b0, 1'b1, 4'h4};
    tv[4]  = '{0, 4'h8, 4'h8, 4'h9, 1'b0, 1'b0, 4'h5};
    tv[5]  = '{1, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1};
    tv[6]  = '{1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h2};
    tv[7]  = '{1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3};
    tv[8]  = '{1, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 4'h4};
    tv[9]  = '{1, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0};
    tv[10] = '{2, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1};
    tv[11] = '{2, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h2};
    tv[12] = '{2, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h4};
    tv[13] = '{2, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h5};
    tv[14] = '{2, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h6};

    // Reset with an arbitrary program present
    for (int i = 0; i < 16; i++) mem4[i] = 8'($urandom);
    do_reset();
    check("rst_pc",   int'(ad4),  0);
    check("rst_a",    int'(a4),   0);
    check("rst_b",    int'(b4),   0);
    check("rst_out",  int'(out4), 0);
    check("rst_c",    int'(c4),   0);
    check("rst_vld",  int'(vld4), 0);
    check("rst_halt", int'(h4),   0);

    // Directed program table
    for (int i = 0; i < 15; i++) begin
      if (i == 0 || tv[i].prog != tv[i-1].prog) begin
        for (int j = 0; j < 16; j++) mem4[j] = 8'h00;
        for (int j = 0; j < 8; j++) mem4[j] = prog_tbl[tv[i].prog][j];
        do_reset();
      end
      tick();
      check($sformatf("tv%0d_pc", i),  int'(ad4),  int'(tv[i].pc));
      check($sformatf("tv%0d_a", i),   int'(a4),   int'(tv[i].a));
      check($sformatf("tv%0d_b", i),   int'(b4),   int'(tv[i].b));
      check($sformatf("tv%0d_out", i), int'(out4), int'(tv[i].o));
      check($sformatf("tv%0d_c", i),   int'(c4),   int'(tv[i].c));
      check($sformatf("tv%0d_vld", i), int'(vld4), int'(tv[i].v));
    end

    // PC wrap through NOPs
    for (int j = 0; j < 16; j++) mem4[j] = 8'h00;
    do_reset();
    for (int j = 0; j < 15; j++) tick();
    check("wrap_pc15", int'(ad4), 15);
    tick();
    check("wrap_pc0", int'(ad4), 0);

    // HLT at address 5 freezes everything until reset
    mem4[0] = 8'h47; mem4[1] = 8'h85; mem4[2] = 8'h1A;
    mem4[3] = 8'h91; mem4[4] = 8'h1F; mem4[5] = 8'hF0;
    do_reset();
    for (int j = 0; j < 5; j++) tick();
    check("pre_hlt_c", int'(c4), 1);
    tick();
    check("hlt_halted", int'(h4), 1);
    check("hlt_pc", int'(ad4), 5);
    mem4[5] = 8'h43;
    for (int j = 0; j < 10; j++) begin
      tick();
      check("hold_pc",  int'(ad4),  5);
      check("hold_a",   int'(a4),   0);
      check("hold_b",   int'(b4),   5);
      check("hold_out", int'(out4), 6);
      check("hold_vld", int'(vld4), 0);
      check("hold_c",   int'(c4),   1);
      check("hold_h",   int'(h4),   1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("unhalt_h",  int'(h4),  0);
    check("unhalt_pc", int'(ad4), 0);

    // Wide core: IN port path and truncated jump target
    mem8[0] = 12'h320;
    mem8[1] = 12'hB45;
    in8 = 8'hF0;
    do_reset();
    tick();
    check("w8_a", int'(a8), 8'h10);
    check("w8_c", int'(c8), 1);
    tick();
    check("w8_jmp_pc", int'(ad8), 5);
    check_model("w8");

`ifdef TD4P_STEP_EN
    // Single-step: state only moves on STEP edges
    for (int j = 0; j < 16; j++) mem4[j] = 8'h00;
    mem4[0] = 8'h43;
    do_reset();
    step = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      check("step0_a",  int'(a4),  0);
      check("step0_pc", int'(ad4), 0);
    end
    step = 1'b1;
    tick();
    check("step1_a",  int'(a4),  3);
    check("step1_pc", int'(ad4), 1);
`endif

    // Randomized programs, inputs, resets (and steps) against the model
    for (int j = 0; j < 16; j++) mem4[j] = 8'($urandom);
    for (int j = 0; j < 64; j++) mem8[j] = 12'($urandom);
    do_reset();
    check_model("rnd_init");
    for (int n = 0; n < 600; n++) begin
      in4 = 4'($urandom);
      in8 = 8'($urandom);
      rst = ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0;
`ifdef TD4P_STEP_EN
      step = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
`endif
      if (n % 150 == 149) begin
        for (int j = 0; j < 16; j++) mem4[j] = 8'($urandom);
        for (int j = 0; j < 64; j++) mem8[j] = 12'($urandom);
      end
      tick();
      check_model("rnd");
    end
    rst = 1'b0;
    step = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
